// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: 6502-side bus controller for one 8 KB RAM and one 8 KB ROM.
// Decodes the CPU address, drives each memory's we/oe and the shared 15-bit address,
// and stalls the CPU through cpu_rdy while a registered memory read completes.
// Optional feature macro: IO_PAGE_EN adds a 256-byte I/O page at IO_BASE
// (offset 0 is the io_out register, other offsets read 0 and ignore writes).
// Bus handshake: a cycle is accepted when cpu_req=1 while the FSM is IDLE
// (cpu_rdy=1); writes and I/O reads finish with zero wait, memory reads drop
// cpu_rdy for READ_LAT+1 clocks and cpu_rdata is valid once cpu_rdy is back high.
// cpu_req is ignored while cpu_rdy=0, so at most one cycle is ever outstanding.
`timescale 1ns/1ps
module mem_bus_ctrl #(
  parameter int unsigned READ_LAT     = 2,
  parameter bit          ROM_WRITABLE = 1'b0,
  parameter logic [15:0] IO_BASE      = 16'h7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        ram_we,
  output logic        rom_we,
  output logic        ram_oe,
  output logic        rom_oe,
  output logic [14:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  output logic [7:0]  io_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rom_sel_q, rom_sel_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdy_q, rdy_d;
  logic        ram_we_q, ram_we_d;
  logic        rom_we_q, rom_we_d;
  logic        ram_oe_q, ram_oe_d;
  logic        rom_oe_q, rom_oe_d;
  logic [7:0]  io_q, io_d;

  logic        is_rom;
  logic        is_io;
  logic        unused_addr_bits;

  assign is_rom = cpu_addr[15];
  // Address bits 14:13 are don't-care for the mirrored memories.
  assign unused_addr_bits = ^cpu_addr[14:13];

`ifdef IO_PAGE_EN
  // I/O page is 256-byte aligned, so a compare of the high byte decodes it.
  assign is_io = (cpu_addr[15:8] == IO_BASE[15:8]);
`else
  assign is_io = 1'b0;
`endif

  // State and output registers; asynchronous reset returns the bus to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rom_sel_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rdy_q     <= 1'b1;
      ram_we_q  <= 1'b0;
      rom_we_q  <= 1'b0;
      ram_oe_q  <= 1'b0;
      rom_oe_q  <= 1'b0;
      io_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rom_sel_q <= rom_sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rdy_q     <= rdy_d;
      ram_we_q  <= ram_we_d;
      rom_we_q  <= rom_we_d;
      ram_oe_q  <= ram_oe_d;
      rom_oe_q  <= rom_oe_d;
      io_q      <= io_d;
    end
  end

  // Next-state and registered-output logic; we strobes default low so they last one clock.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rom_sel_d = rom_sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdy_d     = rdy_q;
    ram_we_d  = 1'b0;
    rom_we_d  = 1'b0;
    ram_oe_d  = ram_oe_q;
    rom_oe_d  = rom_oe_q;
    io_d      = io_q;
    case (state_q)
      IDLE: begin
        rdy_d    = 1'b1;
        ram_oe_d = 1'b0;
        rom_oe_d = 1'b0;
        if (cpu_req) begin
          addr_d = {2'b00, cpu_addr[12:0]};
          if (!cpu_rw) begin
            wdata_d = cpu_wdata;
            if (is_io) begin
              if (cpu_addr == IO_BASE) io_d = cpu_wdata;
            end else if (is_rom) begin
              rom_we_d = ROM_WRITABLE;
            end else begin
              ram_we_d = 1'b1;
            end
          end else if (is_io) begin
            rdata_d = (cpu_addr == IO_BASE) ? io_q : 8'h00;
          end else begin
            rom_sel_d = is_rom;
            ram_oe_d  = ~is_rom;
            rom_oe_d  = is_rom;
            rdy_d     = 1'b0;
            cnt_d     = LAT_M1;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d  = rom_sel_q ? rom_rdata : ram_rdata;
          ram_oe_d = 1'b0;
          rom_oe_d = 1'b0;
          state_d  = RD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rdata   = rdata_q;
  assign cpu_rdy     = rdy_q;
  assign ram_we      = ram_we_q;
  assign rom_we      = rom_we_q;
  assign ram_oe      = ram_oe_q;
  assign rom_oe      = rom_oe_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign io_out      = io_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a default instance (ROM writes dropped) and a second
// instance with ROM_WRITABLE=1 share all inputs. Expected behaviour comes from a
// transaction-level model: address mirroring, region select, read stall length and
// the I/O register value.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

  localparam int          LAT  = 2;
  localparam logic [15:0] IO_B = 16'h7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  ram_rdata, rom_rdata;
  logic [7:0]  cpu_rdata, mem_wdata, io_out;
  logic        cpu_rdy, ram_we, rom_we, ram_oe, rom_oe;
  logic [14:0] mem_address;
  logic [1:0]  dbg_state;

  logic [7:0]  cpu_rdata_rw, mem_wdata_rw, io_out_rw;
  logic        cpu_rdy_rw, ram_we_rw, rom_we_rw, ram_oe_rw, rom_oe_rw;
  logic [14:0] mem_address_rw;
  logic [1:0]  dbg_state_rw;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  io_model = 8'h00;
  logic [14:0] addr_model = 15'h0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.READ_LAT(LAT), .ROM_WRITABLE(1'b0), .IO_BASE(IO_B)) u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rdy(cpu_rdy), .ram_we(ram_we), .rom_we(rom_we), .ram_oe(ram_oe),
    .rom_oe(rom_oe), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .io_out(io_out),
    .dbg_state(dbg_state)
  );

  mem_bus_ctrl #(.READ_LAT(LAT), .ROM_WRITABLE(1'b1), .IO_BASE(IO_B)) u_dut_rw (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_rw),
    .cpu_rdy(cpu_rdy_rw), .ram_we(ram_we_rw), .rom_we(rom_we_rw), .ram_oe(ram_oe_rw),
    .rom_oe(rom_oe_rw), .mem_address(mem_address_rw), .mem_wdata(mem_wdata_rw),
    .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .io_out(io_out_rw),
    .dbg_state(dbg_state_rw)
  );

  function automatic bit addr_is_io(input logic [15:0] a);
`ifdef IO_PAGE_EN
    return (a >= IO_B) && (a <= IO_B + 16'h00FF);
`else
    return 1'b0;
`endif
  endfunction

  // Each memory holds 8 KB, mirrored across its 32 KB half.
  function automatic logic [14:0] mirror(input logic [15:0] a);
    return 15'(a % 16'h2000);
  endfunction

  // One write transaction followed by one idle clock. Called between edges.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input string tag);
    bit io, rom, ram;
    io  = addr_is_io(a);
    rom = (a >= 16'h8000) && !io;
    ram = (a <  16'h8000) && !io;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_req = 1'b0;
    if (!io) addr_model = mirror(a);
    if (io && a == IO_B) io_model = d;
    vectors++;
    if ({ram_we, rom_we, ram_oe, rom_oe, cpu_rdy} !== {ram, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s strobes: got we/oe/rdy=%b required %b", tag,
               {ram_we, rom_we, ram_oe, rom_oe, cpu_rdy}, {ram, 1'b0, 1'b0, 1'b0, 1'b1});
    end
    vectors++;
    if (rom_we_rw !== rom) begin
      miscompares++;
      $display("FAIL %s rom_we(writable): got %b required %b", tag, rom_we_rw, rom);
    end
    if (!io) begin
      vectors++;
      if (mem_address !== addr_model || mem_wdata !== d) begin
        miscompares++;
        $display("FAIL %s addr/data: got %h/%h required %h/%h", tag,
                 mem_address, mem_wdata, addr_model, d);
      end
    end
    vectors++;
    if (io_out !== io_model) begin
      miscompares++;
      $display("FAIL %s io_out: got %h required %h", tag, io_out, io_model);
    end
    @(negedge clk);
    vectors++;
    if ({ram_we, rom_we, rom_we_rw, ram_oe, rom_oe, cpu_rdy} !== 6'b000001) begin
      miscompares++;
      $display("FAIL %s we pulse end: got we/we_rw/oe/rdy=%b required 000001", tag,
               {ram_we, rom_we, rom_we_rw, ram_oe, rom_oe, cpu_rdy});
    end
  endtask

  // One read transaction; returns at the first clock with cpu_rdy high again.
  task automatic do_read(input logic [15:0] a, input logic [7:0] val, input string tag);
    bit         io, rom, sel_oe, oth_oe;
    int         low_cnt, oe_cnt;
    logic [7:0] exp_d;
    io = addr_is_io(a);
    rom = a[15];
    low_cnt = 0; oe_cnt = 0;
    ram_rdata = ~val; rom_rdata = ~val;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    if (io) begin
      @(negedge clk);
      cpu_req = 1'b0;
      exp_d = (a == IO_B) ? io_model : 8'h00;
      vectors++;
      if ({cpu_rdy, ram_oe, rom_oe, ram_we, rom_we} !== 5'b10000 || cpu_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL %s io read: got rdy/oe/we=%b data %h required 10000 data %h", tag,
                 {cpu_rdy, ram_oe, rom_oe, ram_we, rom_we}, cpu_rdata, exp_d);
      end
    end else begin
      addr_model = mirror(a);
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        cpu_req = 1'b0;
        sel_oe = rom ? rom_oe : ram_oe;
        oth_oe = rom ? ram_oe : rom_oe;
        vectors++;
        if (oth_oe || ram_we || rom_we || (sel_oe && mem_address !== addr_model)) begin
          miscompares++;
          $display("FAIL %s bus cycle %0d: got we/oe=%b addr %h required only %s oe, addr %h",
                   tag, n, {ram_we, rom_we, ram_oe, rom_oe}, mem_address,
                   rom ? "rom" : "ram", addr_model);
        end
        if (sel_oe) oe_cnt++;
        // Memory model: data is only presented while output_enable is held.
        if (rom) rom_rdata = sel_oe ? val : ~val;
        else     ram_rdata = sel_oe ? val : ~val;
        if (!cpu_rdy) low_cnt++;
        else break;
      end
      vectors++;
      if (low_cnt != LAT + 1 || oe_cnt != LAT) begin
        miscompares++;
        $display("FAIL %s timing: got rdy-low %0d oe %0d clks required %0d and %0d",
                 tag, low_cnt, oe_cnt, LAT + 1, LAT);
      end
      vectors++;
      if (cpu_rdata !== val || cpu_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s data: got %h rdy %b required %h rdy 1", tag, cpu_rdata, cpu_rdy, val);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    ram_rdata = '0; rom_rdata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ram_we, rom_we, ram_oe, rom_oe, cpu_rdy} !== 5'b00001 || mem_address !== 15'h0 ||
        mem_wdata !== 8'h00 || cpu_rdata !== 8'h00 || io_out !== 8'h00 || dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset values: got we/oe/rdy=%b addr %h wd %h rd %h io %h st %0d",
               {ram_we, rom_we, ram_oe, rom_oe, cpu_rdy}, mem_address, mem_wdata,
               cpu_rdata, io_out, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    // Start a read of $0200 and hit reset while it waits on the memory.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    cpu_req = 1'b0;
    vectors++;
    if (ram_oe !== 1'b1 || cpu_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset pre-abort: got ram_oe %b rdy %b required 1 0", ram_oe, cpu_rdy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ram_we, rom_we, ram_oe, rom_oe, cpu_rdy} !== 5'b00001 || mem_address !== 15'h0 ||
        cpu_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset mid-read: got we/oe/rdy=%b addr %h rd %h required 00001 0 0",
               {ram_we, rom_we, ram_oe, rom_oe, cpu_rdy}, mem_address, cpu_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    io_model = 8'h00;
    addr_model = 15'h0;
    @(negedge clk);
    vectors++;
    if (dbg_state !== 2'd0 || cpu_rdy !== 1'b1 || ram_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset release: got state %0d rdy %b oe %b required 0 1 0",
               dbg_state, cpu_rdy, ram_oe);
    end
  endtask

  task automatic test_ram_write;
    do_write(16'h0123, 8'hA5, "ram_write");
  endtask

  task automatic test_rom_read;
    do_read(16'hFFFC, 8'h01, "rom_read_fffc");
  endtask

  task automatic test_rom_write;
    do_write(16'h8000, 8'h55, "rom_write");
  endtask

  task automatic test_back_to_back;
    do_read(16'h0010, 8'($urandom_range(0, 255)), "b2b_ram");
    do_read(16'h8010, 8'($urandom_range(0, 255)), "b2b_rom");
    do_read(16'h2010, 8'($urandom_range(0, 255)), "b2b_ram_mirror");
  endtask

  task automatic test_idle;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({ram_we, rom_we, ram_oe, rom_oe, cpu_rdy} !== 5'b00001 || mem_address !== addr_model) begin
        miscompares++;
        $display("FAIL idle hold: got we/oe/rdy=%b addr %h required 00001 addr %h",
                 {ram_we, rom_we, ram_oe, rom_oe, cpu_rdy}, mem_address, addr_model);
      end
    end
  endtask

  task automatic test_io_page;
    do_write(16'h7F00, 8'h3C, "io_write");
    do_read(16'h7F00, 8'h3C, "io_read_base");
    do_read(16'h7F05, 8'h9E, "io_read_other");
    do_write(16'h7F05, 8'hC3, "io_write_other");
    do_read(16'h7F00, 8'h3C, "io_read_again");
  endtask

  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) do_read(a, 8'($urandom_range(0, 255)), "rand_read");
      else do_write(a, 8'($urandom_range(0, 255)), "rand_write");
    end
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_back_to_back();
    test_idle();
    test_io_page();
    test_random();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
